// File: rtl/i2c_target.sv
// I2C target endpoint: oversampled SCL/SDA, 7-bit address match, up to four
// bytes written into / read from a 32-bit word, most significant lane first.
`timescale 1ns/1ps
module i2c_target #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  own_addr,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_oe,
    input  logic [31:0] tx_data,
    output logic [31:0] rx_data,
    output logic [3:0]  rx_mask,
    output logic        rx_valid,
    output logic        tx_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   s_scl;
    logic                   s_sda;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [2:0]             bit_cnt;
    logic [1:0]             lane;
    logic [6:0]             shreg;
    logic                   phase;
    logic                   is_read;
    logic [31:0]            tx_word;
    logic [7:0]             tx_byte;
    logic [7:0]             in_byte;

    assign sda_o = 1'b0;

    // Synchronisers idle high so a reset never fabricates a bus condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_q    <= s_scl;
            sda_q    <= s_sda;
        end
    end

    assign s_scl    = scl_sync[SYNC_STAGES-1];
    assign s_sda    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = s_scl & ~scl_q;
    assign scl_fall = ~s_scl & scl_q;
    // SCL must be high in both samples, so an SCL edge masks START/STOP.
    assign start_det = scl_q & s_scl & sda_q & ~s_sda;
    assign stop_det  = scl_q & s_scl & ~sda_q & s_sda;
    assign tx_byte   = tx_word[{lane, 3'b000} +: 8];
    assign in_byte   = {shreg, s_sda};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            rx_data  <= '0;
            rx_mask  <= '0;
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            lane     <= '0;
            shreg    <= '0;
            phase    <= 1'b0;
            is_read  <= 1'b0;
            tx_word  <= '0;
        end else begin
            rx_valid <= 1'b0;
            tx_done  <= 1'b0;
            if (start_det || stop_det) begin
                if (busy) begin
                    if (is_read)
                        tx_done <= 1'b1;
                    else if (rx_mask != 4'd0)
                        rx_valid <= 1'b1;
                end
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                if (stop_det) begin
                    state <= IDLE;
                end else begin
                    state   <= ADDR;
                    bit_cnt <= 3'd7;
                end
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shreg   <= in_byte[6:0];
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            if (shreg == own_addr) begin
                                state   <= ADDR_ACK;
                                phase   <= 1'b0;
                                busy    <= 1'b1;
                                is_read <= s_sda;
                                lane    <= 2'd3;
                                if (s_sda)
                                    tx_word <= tx_data;
                                else
                                    rx_mask <= '0;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            phase   <= 1'b0;
                            bit_cnt <= 3'd7;
                            if (is_read) begin
                                state  <= TX_BYTE;
                                sda_oe <= ~tx_byte[7];
                            end else begin
                                state  <= RX_BYTE;
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RX_BYTE: if (scl_rise) begin
                        shreg   <= in_byte[6:0];
                        bit_cnt <= bit_cnt - 3'd1;
                        if (bit_cnt == 3'd0) begin
                            // Lane 0 already filled: a fifth byte is refused.
                            if (lane == 2'd0 && rx_mask[0]) begin
                                state <= WAIT_STOP;
                            end else begin
                                rx_data[{lane, 3'b000} +: 8] <= in_byte;
                                rx_mask[lane] <= 1'b1;
                                state <= RX_ACK;
                                phase <= 1'b0;
                            end
                        end
                    end
                    RX_ACK: if (scl_fall) begin
                        if (!phase) begin
                            sda_oe <= 1'b1;
                            phase  <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            phase   <= 1'b0;
                            state   <= RX_BYTE;
                            bit_cnt <= 3'd7;
                            if (lane != 2'd0)
                                lane <= lane - 2'd1;
                        end
                    end
                    TX_BYTE: if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe <= 1'b0;
                            state  <= TX_ACK;
                            phase  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            sda_oe  <= ~tx_byte[bit_cnt - 3'd1];
                        end
                    end
                    TX_ACK: begin
                        if (scl_rise) begin
                            if (!s_sda && lane != 2'd0) begin
                                lane  <= lane - 2'd1;
                                phase <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end else if (scl_fall && phase) begin
                            state   <= TX_BYTE;
                            bit_cnt <= 3'd7;
                            phase   <= 1'b0;
                            sda_oe  <= ~tx_byte[7];
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule
